// File: rtl/ps2_pkg.sv
// Shared constants, decoder state and event record for the PS/2 key controller.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Keyboard status / self-test replies that carry no key information.
  localparam int unsigned NumDiscard = 6;
  localparam logic [7:0] DISCARD_CODES [NumDiscard] = '{
    8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF
  };

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } dec_state_e;

  typedef struct packed {
    logic       rpt;
    logic       ext;
    logic       make;
    logic [7:0] scan;
  } key_event_t;

  function automatic logic is_discard(logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NumDiscard; i++) begin
      if (code == DISCARD_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/scan_to_ascii.sv
// Combinational set-2 scan code to ASCII: uppercase letters, digits, space, enter; else 0x00.
module scan_to_ascii (
  input  logic [7:0] scan_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = 8'h00;
    case (scan_i)
      8'h1C: ascii_o = 8'h41;
      8'h32: ascii_o = 8'h42;
      8'h21: ascii_o = 8'h43;
      8'h23: ascii_o = 8'h44;
      8'h24: ascii_o = 8'h45;
      8'h2B: ascii_o = 8'h46;
      8'h34: ascii_o = 8'h47;
      8'h33: ascii_o = 8'h48;
      8'h43: ascii_o = 8'h49;
      8'h3B: ascii_o = 8'h4A;
      8'h42: ascii_o = 8'h4B;
      8'h4B: ascii_o = 8'h4C;
      8'h3A: ascii_o = 8'h4D;
      8'h31: ascii_o = 8'h4E;
      8'h44: ascii_o = 8'h4F;
      8'h4D: ascii_o = 8'h50;
      8'h15: ascii_o = 8'h51;
      8'h2D: ascii_o = 8'h52;
      8'h1B: ascii_o = 8'h53;
      8'h2C: ascii_o = 8'h54;
      8'h3C: ascii_o = 8'h55;
      8'h2A: ascii_o = 8'h56;
      8'h1D: ascii_o = 8'h57;
      8'h22: ascii_o = 8'h58;
      8'h35: ascii_o = 8'h59;
      8'h1A: ascii_o = 8'h5A;
      8'h45: ascii_o = 8'h30;
      8'h16: ascii_o = 8'h31;
      8'h1E: ascii_o = 8'h32;
      8'h26: ascii_o = 8'h33;
      8'h25: ascii_o = 8'h34;
      8'h2E: ascii_o = 8'h35;
      8'h36: ascii_o = 8'h36;
      8'h3D: ascii_o = 8'h37;
      8'h3E: ascii_o = 8'h38;
      8'h46: ascii_o = 8'h39;
      8'h29: ascii_o = 8'h20;
      8'h5A: ascii_o = 8'h0D;
      default: ascii_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Turns a PS/2 set-2 byte stream into make/break/repeat key events, queued in a small FIFO
// with a valid/ready output, plus a press counter and a sticky overflow flag.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter bit          EMIT_REPEAT = 1'b0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_scan,
  output logic             out_ext,
  output logic             out_make,
  output logic             out_repeat,
  output logic [7:0]       out_ascii,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overflow,
  input  logic             clear
);

  localparam int unsigned AW = $clog2(DEPTH);

  dec_state_e state_q, state_d;
  logic       ev_valid, ev_make, ev_ext;

  always_comb begin
    state_d  = state_q;
    ev_valid = 1'b0;
    ev_make  = 1'b1;
    ev_ext   = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StIdle: begin
          if (in_data == SC_EXT) state_d = StExt;
          else if (in_data == SC_BREAK) state_d = StBrk;
          else if (!is_discard(in_data)) ev_valid = 1'b1;
        end
        StExt: begin
          if (in_data == SC_BREAK) state_d = StExtBrk;
          else if (in_data != SC_EXT) begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
            state_d  = StIdle;
          end
        end
        StBrk: begin
          if (in_data == SC_EXT) state_d = StExt;
          else if (in_data != SC_BREAK) begin
            ev_valid = 1'b1;
            ev_make  = 1'b0;
            state_d  = StIdle;
          end
        end
        StExtBrk: begin
          if (in_data == SC_EXT) state_d = StExt;
          else if (in_data != SC_BREAK) begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
            ev_make  = 1'b0;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Typematic repeat detection against the most recently pressed key.
  logic       held_q, held_d, held_ext_q, held_ext_d;
  logic [7:0] held_scan_q, held_scan_d;
  logic       held_match, press_inc, push;
  key_event_t push_ev;

  always_comb begin
    held_match  = held_q && (held_scan_q == in_data) && (held_ext_q == ev_ext);
    press_inc   = ev_valid && ev_make && !held_match;
    push        = ev_valid && (!ev_make || !held_match || EMIT_REPEAT);
    held_d      = held_q;
    held_scan_d = held_scan_q;
    held_ext_d  = held_ext_q;
    if (press_inc) begin
      held_d      = 1'b1;
      held_scan_d = in_data;
      held_ext_d  = ev_ext;
    end else if (ev_valid && !ev_make && held_match) begin
      held_d = 1'b0;
    end
    push_ev.rpt  = ev_make && held_match;
    push_ev.ext  = ev_ext;
    push_ev.make = ev_make;
    push_ev.scan = in_data;
  end

  key_event_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, pop, push_ok, drop;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    out_valid = (count_q != '0);
    full      = count_q[AW];  // DEPTH is a power of two
    pop       = out_valid && out_ready;
    push_ok   = push && (!full || pop);
    drop      = push && full && !pop;
    wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (push_ok && !pop) count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (press_inc) cnt_d = cnt_q + 1'b1;
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      held_q      <= 1'b0;
      held_scan_q <= 8'h00;
      held_ext_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      held_scan_q <= held_scan_d;
      held_ext_q  <= held_ext_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage needs no reset: reads are masked by out_valid.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= push_ev;
  end

  key_event_t head;
  logic [7:0] head_ascii;

  scan_to_ascii u_ascii (
    .scan_i  (head.scan),
    .ascii_o (head_ascii)
  );

  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_scan   = out_valid ? head.scan : 8'h00;
    out_ext    = out_valid && head.ext;
    out_make   = out_valid && head.make;
    out_repeat = out_valid && head.rpt;
    out_ascii  = (out_valid && !head.ext) ? head_ascii : 8'h00;
    press_cnt  = cnt_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench: two DUTs (repeats dropped / emitted) share stimulus; a prefix-flag
// reference model predicts their FIFO contents and a negedge monitor compares.
module tb_ps2_key_ctrl;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, clear;
  logic [7:0] in_data;

  always #5 clk = ~clk;

  logic        v0, x0, m0, r0, o0, v1, x1, m1, r1, o1;
  logic [7:0]  s0, a0, s1, a1;
  logic [15:0] c0, c1;

  ps2_key_ctrl #(.DEPTH(DEPTH), .EMIT_REPEAT(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v0), .out_ready(out_ready), .out_scan(s0), .out_ext(x0), .out_make(m0),
    .out_repeat(r0), .out_ascii(a0), .press_cnt(c0), .overflow(o0), .clear(clear)
  );

  ps2_key_ctrl #(.DEPTH(DEPTH), .EMIT_REPEAT(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v1), .out_ready(out_ready), .out_scan(s1), .out_ext(x1), .out_make(m1),
    .out_repeat(r1), .out_ascii(a1), .press_cnt(c1), .overflow(o1), .clear(clear)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ASCII reference table built from the character lists.
  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                              8'h46};
  logic [7:0] asc_map [logic [7:0]];

  initial begin
    for (int i = 0; i < 26; i++) asc_map[letters[i]] = 8'h41 + 8'(i);
    for (int i = 0; i < 10; i++) asc_map[digits[i]] = 8'h30 + 8'(i);
    asc_map[8'h29] = 8'h20;
    asc_map[8'h5A] = 8'h0D;
  end

  function automatic logic [7:0] ref_ascii(input logic [7:0] sc, input logic ext);
    if (ext || !asc_map.exists(sc)) return 8'h00;
    return asc_map[sc];
  endfunction

  // Reference state: pending prefix flags, held key, per-DUT occupancy and expectations.
  bit          p_ext, p_brk, h_on, h_ext;
  logic [7:0]  h_scan;
  logic [15:0] m_cnt;
  int          occ [2];
  bit          m_ovf [2];
  logic [18:0] exp0 [$];
  logic [18:0] exp1 [$];

  task automatic push_exp(input int k, input logic [18:0] e);
    if (k == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endtask

  initial begin
    forever begin : model
      bit ev, mk, ex, rep, inc, same, want, pp, acc;
      bit drop [2];
      logic [7:0] sc;
      @(posedge clk);
      if (rst) begin
        p_ext = 0; p_brk = 0; h_on = 0; h_ext = 0; h_scan = 8'h00; m_cnt = '0;
        occ[0] = 0; occ[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
        exp0.delete(); exp1.delete();
      end else begin
        ev = 0; mk = 1; ex = 0; rep = 0; inc = 0; sc = in_data;
        drop[0] = 0; drop[1] = 0;
        if (in_valid) begin
          if (in_data == 8'hE0) begin
            p_ext = 1; p_brk = 0;
          end else if (in_data == 8'hF0) begin
            p_brk = 1;
          end else if (!p_ext && !p_brk &&
                       (in_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
            ev = 0;
          end else begin
            ev = 1; mk = !p_brk; ex = p_ext; p_ext = 0; p_brk = 0;
          end
        end
        if (ev) begin
          same = h_on && (h_scan == sc) && (h_ext == ex);
          if (mk) begin
            if (same) rep = 1;
            else begin
              h_on = 1; h_scan = sc; h_ext = ex; inc = 1;
            end
          end else if (same) begin
            h_on = 0;
          end
        end
        for (int k = 0; k < 2; k++) begin
          want = ev && (!rep || k == 1);
          pp   = (occ[k] > 0) && out_ready;
          acc  = 0;
          if (want) begin
            if (occ[k] < DEPTH || pp) begin
              acc = 1;
              push_exp(k, {rep, ex, mk, sc, ref_ascii(sc, ex)});
            end else drop[k] = 1;
          end
          occ[k] = occ[k] + (acc ? 1 : 0) - (pp ? 1 : 0);
        end
        if (clear) begin
          m_cnt = '0; m_ovf[0] = 0; m_ovf[1] = 0;
        end else begin
          if (inc) m_cnt = m_cnt + 16'd1;
          if (drop[0]) m_ovf[0] = 1;
          if (drop[1]) m_ovf[1] = 1;
        end
      end
    end
  end

  task automatic mon_one(input int k, input logic v, r, x, m, input logic [7:0] s, a,
                         input logic [15:0] c, input logic o);
    logic [19:0] expv;
    bit have;
    have = (k == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
    expv = '0;
    if (have) expv = {1'b1, (k == 0) ? exp0[0] : exp1[0]};
    chk($sformatf("event%0d", k), 32'({v, r, x, m, s, a}), 32'(expv));
    chk($sformatf("status%0d", k), 32'({c, o}), 32'({m_cnt, m_ovf[k]}));
    if (have && out_ready) begin
      if (k == 0) void'(exp0.pop_front());
      else void'(exp1.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mon_one(0, v0, r0, x0, m0, s0, a0, c0, o0);
        mon_one(1, v1, r1, x1, m1, s1, a1, c1, o1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [7:0] ten_keys [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                8'h43, 8'h3B};
  logic [7:0] pool [16] = '{8'h1C, 8'h1C, 8'h1B, 8'h16, 8'h45, 8'h29, 8'h5A, 8'h75, 8'h6B,
                            8'h11, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'h00, 8'hFF};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; clear = 1'b0;
    tick();
    tick();
    mon_en = 1'b1;
    rst = 1'b0;
    chk("reset_cnt", 32'(c0), 32'd0);

    // First make with consumer stalled.
    send(8'h1C);
    chk("first_valid", 32'(v0), 32'd1);
    chk("first_ascii", 32'(a0), 32'h41);
    idle(2);
    out_ready = 1'b1;
    idle(2);

    // Typematic repeats.
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    idle(3);
    chk("repeat_cnt", 32'(c0), 32'd1);

    // Extended key and a discarded status byte.
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'hAA);
    idle(3);

    // Overflow, clear, full-with-pop, drain.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(ten_keys[i]);
    chk("ovf_cnt10", 32'(c0), 32'd10);
    chk("ovf_set", 32'(o0), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_cnt", 32'(c0), 32'd0);
    chk("clr_ovf", 32'(o0), 32'd0);
    out_ready = 1'b1;
    send(8'h4B);
    chk("fullpop_ovf", 32'(o0), 32'd0);
    idle(12);

    // Reset in the middle of a break sequence.
    do_reset();
    out_ready = 1'b0;
    send(8'hF0);
    do_reset();
    send(8'h16);
    chk("rst_mid_make", 32'(m0), 32'd1);
    idle(2);
    out_ready = 1'b1;
    idle(3);

    // Randomised traffic with stall bursts, clears and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) out_ready = ($urandom_range(0, 2) != 0);
      else if ($urandom_range(0, 7) == 0) out_ready = ~out_ready;
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = pool[$urandom_range(0, 15)];
      clear    = ($urandom_range(0, 79) == 0);
      rst      = ($urandom_range(0, 699) == 0);
      tick();
    end
    in_valid = 1'b0; clear = 1'b0; rst = 1'b0; out_ready = 1'b1;
    idle(20);
    chk("drained", 32'(v0 | v1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Sequences the raw PS/2 set-2 scan-code byte stream from the PS/2 receiver into discrete key events (make/break, extended, repeat), with per-event ASCII translation.
- Sits between the PS/2 byte receiver and consumers (seven-segment display, keyboard MMIO).
- Buffers events in a small FIFO with a valid/ready output handshake.
- Counts key presses and flags overflow.

Parameters:
DEPTH, 8, event FIFO entries; power of two, minimum 2
EMIT_REPEAT, 0, 1 = emit typematic repeats with repeat flag set; 0 = drop them silently
CNT_W, 16, width of the press counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  one-cycle pulse; in_data holds a complete received byte
in_data  in  8  scan-code byte
out_valid  out  1  FIFO head holds an event
out_ready  in  1  consumer accepts head this cycle
out_scan  out  8  head scan code (prefixes stripped)
out_ext  out  1  head event was E0-prefixed
out_make  out  1  1 = press, 0 = release
out_repeat  out  1  head is a typematic repeat
out_ascii  out  8  ASCII of head; 0x00 if out_ext=1 or code is unmapped
press_cnt  out  CNT_W  accepted non-repeat make events, wraps modulo 2^CNT_W
overflow  out  1  sticky: an event was dropped because the FIFO was full
clear  in  1  clears overflow and press_cnt; has priority over a same-cycle increment

Behaviour:
- Reset is synchronous on rst=1: decoder state = IDLE, FIFO empty, held=0, press_cnt=0, overflow=0. All outputs read 0 (out_* driven 0 while empty).
- Decoder FSM advances only on cycles with in_valid=1:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - AA/FA/FE/EE/00/FF -> discarded, stay IDLE.
    - Any other byte -> make event (ext=0), stay IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay EXT.
    - Other byte -> make event (ext=1), go IDLE.
  - BRK:
    - F0 -> stay BRK.
    - E0 -> EXT (prefix restart).
    - Other byte -> break event (ext=0), go IDLE.
  - EXT_BRK:
    - F0 -> stay EXT_BRK.
    - E0 -> EXT.
    - Other byte -> break event (ext=1), go IDLE.
- Repeat tracking uses held/held_scan/held_ext registers:
  - Make matching {held_scan, held_ext} with held=1 is a repeat: enqueued with repeat=1 if EMIT_REPEAT, else dropped; it never increments press_cnt.
  - Any other make sets held=1, loads {held_scan, held_ext}, and increments press_cnt.
  - Break matching the held key clears held.
  - Break events are always enqueued.
- FIFO entry = {repeat, ext, make, scan}, 11 bits.
  - Enqueue happens on the same edge the FSM consumes the event byte.
  - out_valid is high in cycle N+1 for a byte pulsed in cycle N when the FIFO was empty (1-cycle latency).
  - Pop occurs when out_valid && out_ready.
- Full-FIFO handling:
  - Push with full and no pop: event dropped, overflow set to 1.
  - Push with full and a same-cycle pop: accepted, count unchanged.
  - Push and pop on an empty FIFO: the push is stored; pop is meaningless because out_valid=0.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- A dropped event still updates held state and press_cnt; the FSM is unaffected.
- out_ascii is combinational from the head scan code via scan_to_ascii.
- rst mid-sequence (e.g. after F0) returns the FSM to IDLE. A following bare code is then decoded as a make.

Decomposition:
- Package ps2_pkg holds:
  - Constants SC_BREAK=8'hF0, SC_EXT=8'hE0, and the discard-code list.
  - Decoder state enum IDLE/EXT/BRK/EXT_BRK.
  - Event struct {repeat, ext, make, scan}.
- Sub-module scan_to_ascii, combinational, maps a set-2 code to ASCII:
  - Letters A-Z map to uppercase, e.g. 1C->41, 15->51, 1A->5A.
  - Digits: 45->30, 16->31, 1E->32, 26->33, 25->34, 2E->35, 36->36, 3D->37, 3E->38, 46->39.
  - 29->20 (space), 5A->0D (enter).
  - All other codes -> 00.
- The FIFO stays inline; it is not a separate module.

Test Plan:
- Reset, then pulse 1C with out_ready=0 -> next cycle out_valid=1, scan=1C, make=1, ext=0, repeat=0, ascii=41; press_cnt=1.
- Pulse 1C, 1C, 1C, F0, 1C with EXT_REPEAT... (EMIT_REPEAT=0) and out_ready=1 -> exactly two events: make 1C, then break 1C (ascii 41, make=0); press_cnt=1. Same run with EMIT_REPEAT=1 -> four events, middle two with repeat=1.
- Pulse E0, 75, E0, F0, 75 -> make scan=75 ext=1 ascii=00, then break scan=75 ext=1; pulse AA -> no event.
- DEPTH=8, out_ready=0, ten distinct makes -> first 8 are retained in order, overflow=1, press_cnt=10. Assert clear -> overflow=0, press_cnt=0. Drain -> eight events in order.
- With FIFO full, push a make in the same cycle out_ready=1 -> the new event is accepted, overflow stays 0, count stays 8.
- Pulse F0, assert rst for one cycle, pulse 16 -> make scan=16, ascii=31.
